// File: rtl/mul_pkg.sv
// Shared types and widths for the i8 multiplier leaf and its partial-product rows.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mul_pkg;

    localparam int MUL_W = 8;

    typedef logic [MUL_W-1:0] i8_t;

endpackage

// File: rtl/mul_pp_row.sv
// One shift-add row: running sum plus (b_bit ? a << SHIFT : 0), truncated to WIDTH.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; output follows inputs continuously.
module mul_pp_row #(
    parameter int WIDTH = 8,
    parameter int SHIFT = 0
) (
    input  logic [WIDTH-1:0] sum_in,
    input  logic [WIDTH-1:0] a,
    input  logic             b_bit,
    output logic [WIDTH-1:0] sum_out
);

    logic [WIDTH-1:0] w_pp;

    // Bits shifted past the top are dropped, which is exactly the mod 2^WIDTH wrap we want.
    assign w_pp    = b_bit ? (a << SHIFT) : '0;
    // Carry out of the top bit is discarded by the WIDTH-wide sum.
    assign sum_out = sum_in + w_pp;

endmodule

// File: rtl/mul_i8_i8_i8.sv
// Signed i8 x i8 -> i8 multiply (low 8 bits of the product) built from a shift-add row chain.
// Latency: 0 cycles by default; 1 cycle with MUL_I8_I8_I8_OUT_REG_EN defined (output register).
// Backpressure: none; a new operand pair is accepted every cycle.
module mul_i8_i8_i8
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // w_sum[i] is the running total after rows 0..i-1; the final entry is the truncated product.
    // Low product bits are the same for signed and unsigned operands, so no sign handling is needed.
    logic [WIDTH-1:0] w_sum [0:WIDTH];

    assign w_sum[0] = '0;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_row
        mul_pp_row #(
            .WIDTH (WIDTH),
            .SHIFT (gi)
        ) u_row (
            .sum_in  (w_sum[gi]),
            .a       (a),
            .b_bit   (b[gi]),
            .sum_out (w_sum[gi+1])
        );
    end

`ifdef MUL_I8_I8_I8_OUT_REG_EN
    logic [WIDTH-1:0] r_y;

    // Output register: synchronous clear wins over loading the new product.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_y <= '0;
        end else begin
            r_y <= w_sum[WIDTH];
        end
    end

    assign y = r_y;
`else
    // Clock and reset exist only for interface uniformity in the combinational build.
    logic w_unused_ok;
    assign w_unused_ok = ^{clock, reset};

    assign y = w_sum[WIDTH];
`endif

endmodule

// File: tb/tb_mul_i8_i8_i8.sv
// Self-checking bench for mul_i8_i8_i8, in both the combinational and registered builds.
// Latency: follows the DUT build (0 or 1 cycle), tracked by a scoreboard queue.
// Backpressure: none.
module tb_mul_i8_i8_i8;
    import mul_pkg::*;

`ifdef MUL_I8_I8_I8_OUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    typedef struct {
        string tag;
        i8_t   exp;
    } sb_item_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    i8_t  a     = '0;
    i8_t  b     = '0;
    i8_t  y;

    int n_checks = 0;
    int n_fail   = 0;

    sb_item_t sb_q [$];

    mul_i8_i8_i8 #(.WIDTH(MUL_W)) dut (
        .clock (clock),
        .reset (reset),
        .a     (a),
        .b     (b),
        .y     (y)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input i8_t got, input i8_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: y=%02h expected %02h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: full 16-bit product, keep the low byte.
    function automatic i8_t ref_mul(input i8_t x, input i8_t z);
        logic [15:0] p;
        p = 16'(x) * 16'(z);
        return p[7:0];
    endfunction

    // Drive one operand pair just after the rising edge, push its expectation,
    // then at the falling edge compare the oldest entry once the latency is covered.
    task automatic step(input string tag, input i8_t ta, input i8_t tb_v,
                        input logic rst, input i8_t exp);
        sb_item_t it;
        @(posedge clock);
        #1;
        a     = ta;
        b     = tb_v;
        reset = rst;
        it.tag = tag;
        it.exp = (LAT != 0 && !rst) ? 8'h00 : exp;
        sb_q.push_back(it);
        @(negedge clock);
        if (sb_q.size() > LAT) begin
            it = sb_q.pop_front();
            check_eq(it.tag, y, it.exp);
        end
    endtask

    initial begin
        // Hold reset with 9 x 3 on the inputs.
        reset = 1'b0;
        a     = 8'd9;
        b     = 8'd3;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_eq("in_reset", y, (LAT != 0) ? 8'h00 : 8'h1B);

        step("rst_hold",   8'd9,  8'd3,  1'b0, 8'h1B);
        step("rst_rel",    8'd9,  8'd3,  1'b1, 8'h1B);
        step("after_rel",  8'd9,  8'd3,  1'b1, 8'h1B);

        step("12x-5",      8'd12, 8'hFB, 1'b1, 8'hC4);
        step("0x7f",       8'h00, 8'h7F, 1'b1, 8'h00);
        step("7fx0",       8'h7F, 8'h00, 1'b1, 8'h00);
        step("16x16",      8'd16, 8'd16, 1'b1, 8'h00);
        step("127x127",    8'd127,8'd127,1'b1, 8'h01);
        step("ffxff",      8'hFF, 8'hFF, 1'b1, 8'h01);
        step("80xff",      8'h80, 8'hFF, 1'b1, 8'h80);
        step("80x80",      8'h80, 8'h80, 1'b1, 8'h00);
        step("5x7",        8'd5,  8'd7,  1'b1, 8'd35);

        // Mid-stream reset: registered build must read zero for this slot.
        step("mid_rst",    8'h55, 8'h03, 1'b0, 8'hFF);
        step("post_rst",   8'd7,  8'd7,  1'b1, 8'd49);

        for (int i = 0; i < 1000; i++) begin
            i8_t ra;
            i8_t rb;
            ra = i8_t'($urandom_range(0, 255));
            rb = i8_t'($urandom_range(0, 255));
            step("rand", ra, rb, 1'b1, ref_mul(ra, rb));
        end

        for (int i = 0; i < 256; i++) begin
            for (int j = 0; j < 256; j++) begin
                step("exh", i8_t'(i), i8_t'(j), 1'b1, ref_mul(i8_t'(i), i8_t'(j)));
            end
        end

        // Flush whatever is still in flight in the registered build.
        repeat (LAT) step("drain", 8'h00, 8'h00, 1'b1, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_i8_i8_i8.md
Name: mul_i8_i8_i8

Overview:
- Signed 8-bit × 8-bit multiplier producing an 8-bit result: the low 8 bits of the full product, i.e. two's-complement wrap.
- Primitive arithmetic leaf used by the compiler backend for i8 `mul` instructions.
- Default build is purely combinational (zero latency). Clock and reset exist for interface uniformity and for the optional output register.

Parameters:
- WIDTH, 8, operand and result width in bits. Only 8 is required to be supported; it is the parameter for internal array sizing.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous reset, active-low. Sampled on rising clock edge; asserted when 0.
- a  input  8  multiplicand, signed two's complement.
- b  input  8  multiplier, signed two's complement.
- y  output  8  product, low 8 bits of a*b, signed two's complement.

Behaviour:
- y = (a * b) mod 2^8. Upper product bits are discarded; there is no overflow or saturation flag.
- Signed and unsigned interpretations give identical low 8 bits, so no sign-extension logic is needed for the result.
- Implemented as an explicit shift-add array:
  - Partial product row i = (b[i] ? a << i : 0), truncated to 8 bits.
  - Rows are summed by a chain of 8-bit adders with carries out of bit 7 dropped.
  - No use of the `*` operator.
- Default build, latency 0:
  - y follows a and b combinationally within the same cycle.
  - y is valid whenever a and b are stable, including while reset is asserted.
  - reset and clock have no functional effect.
- Boundary conditions:
  - 0 × anything = 0.
  - 0x80 × 0xFF (−128 × −1) = 0x80 (wraps).
  - 0xFF × 0xFF = 0x01.
  - 127 × 127 = 0x01.
  - 16 × 16 = 0x00.
- No internal state in the default build. Any X on an input propagates to y.

Optional Feature:
- Macro: MUL_I8_I8_I8_OUT_REG_EN.
- When defined:
  - y is driven from an 8-bit output register loaded with the combinational product on every rising clock edge.
  - Latency is 1 cycle.
  - When reset = 0 at a rising edge, the register clears to 0x00; reset takes priority over the load.
  - y reads 0x00 in the first cycle after reset deasserts, then the product of the operands sampled at the previous edge.
- When undefined:
  - No registers.
  - Latency is 0, as described in Behaviour.

Decomposition:
- Shared package mul_pkg:
  - localparam MUL_W = 8.
  - typedef logic [MUL_W-1:0] i8_t, used for a, b and y.
- Natural sub-module: mul_pp_row.
  - Inputs: running sum, a, one bit b[i], shift index i.
  - Output: running sum + (b[i] ? a<<i : 0), 8-bit truncated.
  - The top level instantiates eight rows in a generate loop, plus the optional register.

Test Plan:
- Default build: hold reset=0 with a=9, b=3, then deassert reset → y=27 (0x1B) in the first cycle after reset.
- a=12, b=−5 (0xFB) → y=0xC4 (−60); a=0, b=0x7F → y=0x00.
- Wrap cases:
  - a=16, b=16 → y=0x00.
  - a=127, b=127 → y=0x01.
  - a=0xFF, b=0xFF → y=0x01.
- a=0x80, b=0xFF → y=0x80; a=0x80, b=0x80 → y=0x00.
- Randomised sweep of 1000 pairs, plus exhaustive 65536 if time permits → y equals low 8 bits of a*b every cycle.
- Built with MUL_I8_I8_I8_OUT_REG_EN:
  - With a=9, b=3, y=0x00 while reset=0 and in the first cycle after reset.
  - y=27 one cycle later.
  - Asserting reset mid-stream clears y to 0x00 at the next edge.
